gpio_arbiter: RTL and testbench

GPIO_ARBITER -- requirements
Module: gpio_arbiter

---
 rtl/gpio_arbiter.sv | 144 ++++++++++++++
 tb/tb_gpio_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_arbiter.sv
// Two-requester round-robin arbiter driving a simple register bus with a
// SETUP / STROBE / HOLD access sequence; every output comes straight from a flop.
module gpio_arbiter #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [3:0]  Addr0,
    input  logic [3:0]  Addr1,
    input  logic [15:0] Data0,
    input  logic [15:0] Data1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [15:0] RdData,
    output logic        Busy,
    output logic [3:0]  BusAddr,
    output logic [15:0] BusDataWr,
    input  logic [15:0] BusDataRd,
    output logic        BusEn,
    output logic        BusRd,
    output logic        BusWr
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;    // last granted requester, also the active one
    logic        wr_q, wr_d;
    logic [3:0]  bus_addr_q, bus_addr_d;
    logic [15:0] bus_data_wr_q, bus_data_wr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        bus_en_q, bus_en_d;
    logic        bus_rd_q, bus_rd_d;
    logic        bus_wr_q, bus_wr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        pick1;

    // Requester 1 wins when alone, or on contention when 0 was granted last.
    assign pick1 = Req1 & (~Req0 | ~last_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        wr_d          = wr_q;
        bus_addr_d    = bus_addr_q;
        bus_data_wr_d = bus_data_wr_q;
        rd_data_d     = rd_data_q;
        bus_en_d      = bus_en_q;
        bus_rd_d      = 1'b0;
        bus_wr_d      = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        case (state_q)
            StIdle: begin
                bus_en_d = 1'b0;
                if (Req0 || Req1) begin
                    state_d       = StSetup;
                    last_d        = pick1;
                    wr_d          = pick1 ? Write1 : Write0;
                    bus_addr_d    = pick1 ? Addr1 : Addr0;
                    bus_data_wr_d = pick1 ? Data1 : Data0;
                    bus_en_d      = 1'b1;
                end
            end
            StSetup: begin
                state_d  = StStrobe;
                cnt_d    = 4'(STROBE_CYCLES - 1);
                bus_wr_d = wr_q;
                bus_rd_d = ~wr_q;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    if (!wr_q) begin
                        rd_data_d = BusDataRd;
                    end
                    ack0_d = ~last_q;
                    ack1_d = last_q;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    bus_wr_d = wr_q;
                    bus_rd_d = ~wr_q;
                end
            end
            StHold: begin
                state_d  = StIdle;
                bus_en_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            last_q        <= 1'b1;
            wr_q          <= 1'b0;
            bus_addr_q    <= 4'd0;
            bus_data_wr_q <= 16'h0000;
            rd_data_q     <= 16'h0000;
            bus_en_q      <= 1'b0;
            bus_rd_q      <= 1'b0;
            bus_wr_q      <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            wr_q          <= wr_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_wr_q <= bus_data_wr_d;
            rd_data_q     <= rd_data_d;
            bus_en_q      <= bus_en_d;
            bus_rd_q      <= bus_rd_d;
            bus_wr_q      <= bus_wr_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            busy_q        <= busy_d;
        end
    end

    assign Ack0      = ack0_q;
    assign Ack1      = ack1_q;
    assign RdData    = rd_data_q;
    assign Busy      = busy_q;
    assign BusAddr   = bus_addr_q;
    assign BusDataWr = bus_data_wr_q;
    assign BusEn     = bus_en_q;
    assign BusRd     = bus_rd_q;
    assign BusWr     = bus_wr_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: main instance with STROBE_CYCLES=2 plus
// 1- and 15-cycle instances sharing the same stimulus for strobe-width checks.
module tb_gpio_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        Req0 = 1'b0, Req1 = 1'b0, Write0 = 1'b0, Write1 = 1'b0;
    logic [3:0]  Addr0 = 4'd0, Addr1 = 4'd0;
    logic [15:0] Data0 = 16'h0, Data1 = 16'h0, BusDataRd = 16'h0;

    logic        ack0, ack1, busy, bus_en, bus_rd, bus_wr;
    logic [15:0] rd_data, bus_data_wr;
    logic [3:0]  bus_addr;

    logic        ack0_a, ack1_a, busy_a, bus_en_a, bus_rd_a, bus_wr_a;
    logic [15:0] rd_data_a, bus_data_wr_a;
    logic [3:0]  bus_addr_a;

    logic        ack0_b, ack1_b, busy_b, bus_en_b, bus_rd_b, bus_wr_b;
    logic [15:0] rd_data_b, bus_data_wr_b;
    logic [3:0]  bus_addr_b;

    int total = 0, passed = 0, failed = 0;
    int wr_cnt2, wr_cnt1, wr_cnt15, ack_cnt2, ack_cnt1, ack_cnt15;

    always #5 Clk = ~Clk;

    gpio_arbiter #(.STROBE_CYCLES(2)) dut (
        .Clk(Clk), .ResetN(ResetN), .Req0(Req0), .Req1(Req1),
        .Write0(Write0), .Write1(Write1), .Addr0(Addr0), .Addr1(Addr1),
        .Data0(Data0), .Data1(Data1), .Ack0(ack0), .Ack1(ack1),
        .RdData(rd_data), .Busy(busy), .BusAddr(bus_addr), .BusDataWr(bus_data_wr),
        .BusDataRd(BusDataRd), .BusEn(bus_en), .BusRd(bus_rd), .BusWr(bus_wr)
    );

    gpio_arbiter #(.STROBE_CYCLES(1)) dut1 (
        .Clk(Clk), .ResetN(ResetN), .Req0(Req0), .Req1(Req1),
        .Write0(Write0), .Write1(Write1), .Addr0(Addr0), .Addr1(Addr1),
        .Data0(Data0), .Data1(Data1), .Ack0(ack0_a), .Ack1(ack1_a),
        .RdData(rd_data_a), .Busy(busy_a), .BusAddr(bus_addr_a),
        .BusDataWr(bus_data_wr_a), .BusDataRd(BusDataRd), .BusEn(bus_en_a),
        .BusRd(bus_rd_a), .BusWr(bus_wr_a)
    );

    gpio_arbiter #(.STROBE_CYCLES(15)) dut15 (
        .Clk(Clk), .ResetN(ResetN), .Req0(Req0), .Req1(Req1),
        .Write0(Write0), .Write1(Write1), .Addr0(Addr0), .Addr1(Addr1),
        .Data0(Data0), .Data1(Data1), .Ack0(ack0_b), .Ack1(ack1_b),
        .RdData(rd_data_b), .Busy(busy_b), .BusAddr(bus_addr_b),
        .BusDataWr(bus_data_wr_b), .BusDataRd(BusDataRd), .BusEn(bus_en_b),
        .BusRd(bus_rd_b), .BusWr(bus_wr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // {Busy, BusEn, BusWr, BusRd, Ack1, Ack0}
    function automatic logic [5:0] ctl();
        return {busy, bus_en, bus_wr, bus_rd, ack1, ack0};
    endfunction

    initial begin
        // Reset values, checked before any clock edge
        #2;
        check("rst_ctl", {26'd0, ctl()}, 32'h0);
        check("rst_addr", {28'd0, bus_addr}, 32'h0);
        check("rst_wdata", {16'd0, bus_data_wr}, 32'h0);
        check("rst_rdata", {16'd0, rd_data}, 32'h0);
        #5 ResetN = 1'b1;
        tick();

        // Single write from requester 0
        Req0 = 1'b1; Write0 = 1'b1; Addr0 = 4'h1; Data0 = 16'hA5C3;
        tick();
        check("wr_setup_ctl", {26'd0, ctl()}, 32'b110000);
        check("wr_setup_addr", {28'd0, bus_addr}, 32'h1);
        check("wr_setup_data", {16'd0, bus_data_wr}, 32'hA5C3);
        tick();
        check("wr_strobe1_ctl", {26'd0, ctl()}, 32'b111000);
        tick();
        check("wr_strobe2_ctl", {26'd0, ctl()}, 32'b111000);
        tick();
        check("wr_hold_ctl", {26'd0, ctl()}, 32'b110001);
        check("wr_hold_addr", {12'd0, bus_addr, bus_data_wr}, 32'h1A5C3);
        Req0 = 1'b0;
        tick();
        check("wr_idle_ctl", {26'd0, ctl()}, 32'b000000);
        check("wr_idle_hold", {12'd0, bus_addr, bus_data_wr}, 32'h1A5C3);

        // Single read from requester 1
        Req1 = 1'b1; Write1 = 1'b0; Addr1 = 4'h1; BusDataRd = 16'h00FF;
        tick();
        check("rd_setup_ctl", {26'd0, ctl()}, 32'b110000);
        tick();
        check("rd_strobe1_ctl", {26'd0, ctl()}, 32'b110100);
        tick();
        check("rd_strobe2_ctl", {26'd0, ctl()}, 32'b110100);
        tick();
        check("rd_hold_ctl", {26'd0, ctl()}, 32'b110010);
        check("rd_hold_rdata", {16'd0, rd_data}, 32'h00FF);
        Req1 = 1'b0; BusDataRd = 16'h1234;
        tick();
        check("rd_idle_ctl", {26'd0, ctl()}, 32'b000000);
        check("rd_data_held", {16'd0, rd_data}, 32'h00FF);

        // Contention from reset: order 0,1,0,1 with Acks 5 cycles apart
        #3 ResetN = 1'b0;
        #1 ResetN = 1'b1;
        Req0 = 1'b1; Write0 = 1'b1; Addr0 = 4'h2; Data0 = 16'h2222;
        Req1 = 1'b1; Write1 = 1'b1; Addr1 = 4'h3; Data1 = 16'h3333;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("rr_ack_c%0d", i), {30'd0, ack1, ack0},
                  (i == 4 || i == 14) ? 32'b01 : (i == 9 || i == 19) ? 32'b10 : 32'b00);
            if (i == 1 || i == 11) check($sformatf("rr_addr_c%0d", i), {28'd0, bus_addr}, 32'h2);
            if (i == 6 || i == 16) check($sformatf("rr_addr_c%0d", i), {28'd0, bus_addr}, 32'h3);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();

        // Mid-transaction input changes are ignored; Req1 waits
        Req0 = 1'b1; Write0 = 1'b1; Addr0 = 4'h5; Data0 = 16'h1234;
        tick();
        tick();
        Addr0 = 4'h9; Data0 = 16'hFFFF; Write0 = 1'b0;
        Req1 = 1'b1; Write1 = 1'b1; Addr1 = 4'h6; Data1 = 16'hBEEF;
        tick();
        check("mid_strobe2", {11'd0, bus_wr, bus_addr, bus_data_wr}, {11'd0, 1'b1, 4'h5, 16'h1234});
        tick();
        check("mid_hold_ctl", {26'd0, ctl()}, 32'b110001);
        check("mid_hold_addr", {12'd0, bus_addr, bus_data_wr}, 32'h51234);
        Req0 = 1'b0;
        tick();
        check("mid_idle_busy", {31'd0, busy}, 32'h0);
        tick();
        check("mid_req1_setup", {11'd0, busy, bus_addr, bus_data_wr}, {11'd0, 1'b1, 4'h6, 16'hBEEF});
        tick();
        tick();
        tick();
        check("mid_req1_ack", {26'd0, ctl()}, 32'b110010);
        Req1 = 1'b0;
        tick();

        // Asynchronous reset during a write strobe
        Req0 = 1'b1; Write0 = 1'b1; Addr0 = 4'h7; Data0 = 16'h5555;
        tick();
        tick();
        check("ar_strobe", {26'd0, ctl()}, 32'b111000);
        #2 ResetN = 1'b0;
        #1;
        check("ar_async_ctl", {26'd0, ctl()}, 32'h0);
        check("ar_async_addr", {12'd0, bus_addr, bus_data_wr}, 32'h0);
        tick();
        check("ar_no_ack", {26'd0, ctl()}, 32'h0);
        #3 ResetN = 1'b1;
        tick();
        check("ar_regrant", {11'd0, bus_en, bus_addr, bus_data_wr}, {11'd0, 1'b1, 4'h7, 16'h5555});
        tick();
        tick();
        tick();
        check("ar_reack", {26'd0, ctl()}, 32'b110001);
        Req0 = 1'b0;
        tick();

        // Strobe widths 2, 1 and 15 from a single request
        #2 ResetN = 1'b0;
        #1 ResetN = 1'b1;
        Req0 = 1'b1; Write0 = 1'b1; Addr0 = 4'hA; Data0 = 16'h0F0F;
        tick();
        Req0 = 1'b0;
        wr_cnt2 = 0; wr_cnt1 = 0; wr_cnt15 = 0;
        ack_cnt2 = 0; ack_cnt1 = 0; ack_cnt15 = 0;
        for (int i = 0; i < 25; i++) begin
            wr_cnt2 += int'(bus_wr);
            wr_cnt1 += int'(bus_wr_a);
            wr_cnt15 += int'(bus_wr_b);
            ack_cnt2 += int'(ack0);
            ack_cnt1 += int'(ack0_a);
            ack_cnt15 += int'(ack0_b);
            tick();
        end
        check("width_2", wr_cnt2, 32'd2);
        check("width_1", wr_cnt1, 32'd1);
        check("width_15", wr_cnt15, 32'd15);
        check("acks_2", ack_cnt2, 32'd1);
        check("acks_1", ack_cnt1, 32'd1);
        check("acks_15", ack_cnt15, 32'd1);
        check("width_idle", {26'd0, busy_a, busy_b, bus_en_a, bus_en_b, 2'b00}, 32'h0);

        if (passed + failed != total) $error("FAIL check_count: %0d+%0d vs %0d", passed, failed, total);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
